// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the iterative divide controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package div_ctrl_pkg;

    localparam int DIV_OP_WD  = 4;
    localparam int DIV_CNT_WD = 5;

    // One-hot operation bit positions: {modu, divu, mod, div}
    localparam int OP_DIV  = 0;
    localparam int OP_MOD  = 1;
    localparam int OP_DIVU = 2;
    localparam int OP_MODU = 3;

    typedef enum logic [2:0] {
        DIV_ST_IDLE = 3'd0,
        DIV_ST_PREP = 3'd1,
        DIV_ST_CALC = 3'd2,
        DIV_ST_FIX  = 3'd3,
        DIV_ST_DONE = 3'd4
    } div_state_e;

    function automatic logic op_is_onehot(input logic [DIV_OP_WD-1:0] op);
        return (op != '0) && ((op & (op - {{(DIV_OP_WD-1){1'b0}}, 1'b1})) == '0);
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response handshake bundle between the EX stage and the divide controller.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, resp_valid/resp_ready on the response side.
// master = EX stage (issues requests, consumes results); slave = div_ctrl.
interface div_ctrl_if;
    import div_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [DIV_OP_WD-1:0] req_op;
    logic [31:0]          req_src1;
    logic [31:0]          req_src2;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_result;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_result
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_result
    );

endinterface

// File: rtl/div_iter_unit.sv
// Combinational restoring-division stage resolving BITS quotient bits of {rem,quo}.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when to register rq_out.
// Ports: rq_in {rem,quo} 64b, dvs divisor 32b, rq_out next {rem,quo} 64b.
module div_iter_unit #(
    parameter int BITS = 1
) (
    input  logic [63:0] rq_in,
    input  logic [31:0] dvs,
    output logic [63:0] rq_out
);

    logic [BITS:0][63:0] stage;

    assign stage[0] = rq_in;

    for (genvar i = 0; i < BITS; i++) begin : g_step
        // Partial remainder shifted left with the next dividend bit; 33 bits
        // because an unsigned divisor can exceed 2^31.
        logic [32:0] shifted;
        logic        take;
        logic [31:0] diff;

        assign shifted = stage[i][63:31];
        assign take    = (shifted >= {1'b0, dvs});
        // When take is set the true difference is below dvs, so 32 bits suffice.
        assign diff    = shifted[31:0] - dvs;
        assign stage[i+1] = take ? {diff,          stage[i][30:0], 1'b1}
                                 : {shifted[31:0], stage[i][30:0], 1'b0};
    end

    assign rq_out = stage[BITS];

endmodule

// File: rtl/div_ctrl.sv
// Iterative div.w/mod.w/div.wu/mod.wu controller beside the EX-stage ALU; one op in flight, flush cancels.
// Latency: response valid 3+32/BITS_PER_CYC cycles after the acceptance edge (2 on early-out).
// Backpressure: req_ready only in IDLE; DONE holds the result until resp_ready, then one idle bubble.
// Ports: clk, reset (async active-low), flush, busy, bus (div_ctrl_if.slave: req_* / resp_*).
// Build option: DIV_EARLY_OUT_EN skips CALC/FIX when divisor==0 or |src1|<|src2|.
// BITS_PER_CYC must be 1, 2 or 4.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    output logic        busy,
    div_ctrl_if.slave   bus
);

    // Counter holds remaining CALC cycles minus one; CALC exits when it reads 0.
    localparam logic [DIV_CNT_WD-1:0] CNT_LOAD = DIV_CNT_WD'(32 / BITS_PER_CYC - 1);

    div_state_e           state_q,  state_d;
    logic [DIV_CNT_WD-1:0] cnt_q,   cnt_d;
    logic [DIV_OP_WD-1:0] op_q,     op_d;
    logic [31:0]          src1_q,   src1_d;
    logic [31:0]          src2_q,   src2_d;
    logic [63:0]          rq_q,     rq_d;
    logic [31:0]          dvs_q,    dvs_d;
    logic                 qneg_q,   qneg_d;
    logic                 rneg_q,   rneg_d;
    logic                 dz_q,     dz_d;
    logic [31:0]          result_q, result_d;

    logic        signed_op;
    logic        is_quo_op;
    logic        op_ok;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [63:0] rq_iter;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    div_iter_unit #(
        .BITS (BITS_PER_CYC)
    ) u_iter (
        .rq_in  (rq_q),
        .dvs    (dvs_q),
        .rq_out (rq_iter)
    );

    assign signed_op = op_q[OP_DIV] | op_q[OP_MOD];
    assign is_quo_op = op_q[OP_DIV] | op_q[OP_DIVU];
    assign op_ok     = op_is_onehot(op_q);

    assign abs1 = (signed_op && src1_q[31]) ? neg32(src1_q) : src1_q;
    assign abs2 = (signed_op && src2_q[31]) ? neg32(src2_q) : src2_q;

    // Divide-by-zero bypasses the sign fix: remainder is the raw dividend.
    // 0x80000000 / -1 needs no special case: |x| arithmetic yields 0x80000000.
    assign quo_fix = dz_q ? 32'hFFFF_FFFF : (qneg_q ? neg32(rq_q[31:0])  : rq_q[31:0]);
    assign rem_fix = dz_q ? src1_q        : (rneg_q ? neg32(rq_q[63:32]) : rq_q[63:32]);

    assign fix_result = !op_ok    ? 32'd0 :
                        is_quo_op ? quo_fix : rem_fix;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        rq_d     = rq_q;
        dvs_d    = dvs_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        result_d = result_q;

        if (flush) begin
            state_d = DIV_ST_IDLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: begin
                    if (bus.req_valid) begin
                        state_d = DIV_ST_PREP;
                        op_d    = bus.req_op;
                        src1_d  = bus.req_src1;
                        src2_d  = bus.req_src2;
                    end
                end
                DIV_ST_PREP: begin
                    rq_d   = {32'd0, abs1};
                    dvs_d  = abs2;
                    qneg_d = signed_op & (src1_q[31] ^ src2_q[31]);
                    rneg_d = signed_op & src1_q[31];
                    dz_d   = (src2_q == 32'd0);
`ifdef DIV_EARLY_OUT_EN
                    if ((src2_q == 32'd0) || (abs1 < abs2)) begin
                        state_d = DIV_ST_DONE;
                        if (!op_ok)
                            result_d = 32'd0;
                        else if (is_quo_op)
                            result_d = (src2_q == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                        else
                            result_d = src1_q;
                    end else begin
                        state_d = DIV_ST_CALC;
                        cnt_d   = CNT_LOAD;
                    end
`else
                    state_d = DIV_ST_CALC;
                    cnt_d   = CNT_LOAD;
`endif
                end
                DIV_ST_CALC: begin
                    rq_d = rq_iter;
                    if (cnt_q == '0)
                        state_d = DIV_ST_FIX;
                    else
                        cnt_d = cnt_q - DIV_CNT_WD'(1);
                end
                DIV_ST_FIX: begin
                    result_d = fix_result;
                    state_d  = DIV_ST_DONE;
                end
                DIV_ST_DONE: begin
                    if (bus.resp_ready)
                        state_d = DIV_ST_IDLE;
                end
                default: begin
                    state_d = DIV_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= DIV_ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            rq_q     <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            rq_q     <= rq_d;
            dvs_q    <= dvs_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            result_q <= result_d;
        end
    end

    assign bus.req_ready   = (state_q == DIV_ST_IDLE) && !flush;
    assign bus.resp_valid  = (state_q == DIV_ST_DONE);
    assign bus.resp_result = result_q;
    assign busy            = (state_q != DIV_ST_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table plus hold, flush and reset sequences.
// Latency: checks full latency (or early-out latency when DIV_EARLY_OUT_EN is defined).
// Backpressure: exercises resp_ready held low in DONE and flush in every relevant state.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    div_ctrl_if dif ();

    div_ctrl #(
        .BITS_PER_CYC (1)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] OPC_DIV  = 4'b0001;
    localparam logic [3:0] OPC_MOD  = 4'b0010;
    localparam logic [3:0] OPC_DIVU = 4'b0100;
    localparam logic [3:0] OPC_MODU = 4'b1000;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO_ON = 1'b1;
`else
    localparam bit EO_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          eo;     // early-out eligible (divisor 0 or |a|<|b|)
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one request; returns #1 after the acceptance edge (cycle 0).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("req_ready before issue", 32'(dif.req_ready), 32'd1);
        dif.req_valid = 1'b1;
        dif.req_op    = op;
        dif.req_src1  = a;
        dif.req_src2  = b;
        @(posedge clk);
        #1;
        dif.req_valid = 1'b0;
    endtask

    // Counts cycles from acceptance until resp_valid, checking busy on the way.
    task automatic wait_resp(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!dif.resp_valid && lat < 200);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        bit bok;
        dif.resp_ready = 1'b1;
        issue(v.op, v.a, v.b);
        wait_resp(lat, bok);
        check({v.name, " latency"}, 32'(lat), (EO_ON && v.eo) ? 32'd2 : 32'd35);
        check({v.name, " result"}, dif.resp_result, v.exp);
        check({v.name, " busy"}, 32'(bok), 32'd1);
        @(negedge clk);
        check({v.name, " idle after handshake"},
              32'({busy, dif.resp_valid, dif.req_ready}), 32'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit bok;

        dif.req_valid  = 1'b0;
        dif.req_op     = '0;
        dif.req_src1   = '0;
        dif.req_src2   = '0;
        dif.resp_ready = 1'b1;

        vecs.push_back('{OPC_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div 100/-7"});
        vecs.push_back('{OPC_MOD,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, "mod -100%7"});
        vecs.push_back('{OPC_MODU, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 1'b0, "modu ffffffff%16"});
        vecs.push_back('{OPC_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0, "divu ffffffff/2"});
        vecs.push_back('{OPC_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "divu 5/0"});
        vecs.push_back('{OPC_MOD,  32'd5,         32'd0,         32'h0000_0005, 1'b1, "mod 5%0"});
        vecs.push_back('{OPC_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div ovf"});
        vecs.push_back('{OPC_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mod ovf"});
        vecs.push_back('{OPC_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div -7/2"});
        vecs.push_back('{OPC_MOD,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "mod -7%2"});
        vecs.push_back('{OPC_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1, "div -5/0"});
        vecs.push_back('{OPC_MOD,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, "mod -5%0"});
        vecs.push_back('{OPC_MODU, 32'd5,         32'd0,         32'h0000_0005, 1'b1, "modu 5%0"});
        vecs.push_back('{OPC_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "divu 80000000/ffffffff"});
        vecs.push_back('{OPC_DIVU, 32'd3,         32'd10,        32'h0000_0000, 1'b1, "divu 3/10"});
        vecs.push_back('{4'b0011,  32'd100,       32'd7,         32'h0000_0000, 1'b0, "non-onehot op"});
        vecs.push_back('{OPC_DIV,  32'd9,         32'd3,         32'h0000_0003, 1'b0, "div 9/3"});

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset resp_valid", 32'(dif.resp_valid), 32'd0);
        check("reset resp_result", dif.resp_result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready after reset", 32'(dif.req_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // resp_ready held low for 5 cycles in DONE
        dif.resp_ready = 1'b0;
        issue(OPC_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_resp(lat, bok);
        check("hold latency", 32'(lat), 32'd35);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold resp_valid", 32'(dif.resp_valid), 32'd1);
            check("hold resp_result", dif.resp_result, 32'hFFFF_FFF2);
            check("hold req_ready", 32'(dif.req_ready), 32'd0);
        end
        dif.resp_ready = 1'b1;
        #1;
        check("done bubble req_ready", 32'(dif.req_ready), 32'd0);
        @(negedge clk);
        check("hold idle after handshake",
              32'({busy, dif.resp_valid, dif.req_ready}), 32'b001);

        // flush mid-CALC, then a fresh op
        issue(OPC_DIV, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush masks req_ready", 32'(dif.req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush -> idle", 32'({busy, dif.resp_valid}), 32'd0);
        repeat (40) @(negedge clk);
        check("no resp after flush", 32'(dif.resp_valid), 32'd0);
        run_vec('{OPC_DIV, 32'd9, 32'd3, 32'd3, 1'b0, "div 9/3 after flush"});

        // flush together with req_valid in IDLE: not accepted
        @(negedge clk);
        flush         = 1'b1;
        dif.req_valid = 1'b1;
        dif.req_op    = OPC_DIV;
        dif.req_src1  = 32'd8;
        dif.req_src2  = 32'd2;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        dif.req_valid = 1'b0;
        check("flush+req not accepted", 32'(busy), 32'd0);

        // flush in DONE with resp_ready: response discarded
        dif.resp_ready = 1'b0;
        issue(OPC_DIV, 32'd9, 32'd3);
        wait_resp(lat, bok);
        check("pre-flush resp_valid", 32'(dif.resp_valid), 32'd1);
        flush          = 1'b1;
        dif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush in DONE", 32'({busy, dif.resp_valid}), 32'd0);

        // asynchronous reset mid-CALC
        issue(OPC_DIVU, 32'hFFFF_FFFF, 32'd2);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset busy/valid", 32'({busy, dif.resp_valid}), 32'd0);
        check("async reset resp_result", dif.resp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready after mid-op reset", 32'(dif.req_ready), 32'd1);
        check("no resp after mid-op reset", 32'(dif.resp_valid), 32'd0);
        run_vec('{OPC_MOD, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b0, "mod after reset"});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
